// File: rtl/core_alu_serial_if.sv
// core_alu_serial_if: request/operand/flag bundle between a requester and the serial ALU.
interface core_alu_serial_if #(parameter int WIDTH = 16);
  logic             I_start;
  logic [2:0]       I_op;
  logic             I_decimal;
  logic             I_flag_we;
  logic [WIDTH-1:0] I_lhs;
  logic [WIDTH-1:0] I_rhs;
  logic             I_carry;
  logic             I_overflow;
  logic             I_sign;
  logic             I_zero;
  logic             O_busy;
  logic             O_done;
  logic [WIDTH-1:0] O_result;
  logic             O_carry;
  logic             O_overflow;
  logic             O_sign;
  logic             O_zero;
  modport master (
    output I_start, I_op, I_decimal, I_flag_we, I_lhs, I_rhs,
           I_carry, I_overflow, I_sign, I_zero,
    input  O_busy, O_done, O_result, O_carry, O_overflow, O_sign, O_zero
  );
  modport slave (
    input  I_start, I_op, I_decimal, I_flag_we, I_lhs, I_rhs,
           I_carry, I_overflow, I_sign, I_zero,
    output O_busy, O_done, O_result, O_carry, O_overflow, O_sign, O_zero
  );
endinterface

// File: rtl/core_alu_serial.sv
// core_alu_serial: byte-serial 6502-style ALU (binary/BCD add/sub, logic, rotates) with flag update.
module core_alu_serial #(
  parameter int WIDTH      = 16,
  parameter bit DECIMAL_EN = 1'b1
) (
  input logic               I_clock,
  input logic               I_reset_n,
  core_alu_serial_if.slave  bus
);
  localparam int BYTES = WIDTH / 8;
  localparam logic [2:0] OP_PASS = 3'd0, OP_ADC = 3'd1, OP_SBC = 3'd2, OP_AND = 3'd3,
                         OP_ORA  = 3'd4, OP_EOR = 3'd5, OP_ROL = 3'd6, OP_ROR = 3'd7;
  if (WIDTH != 8 && WIDTH != 16 && WIDTH != 24 && WIDTH != 32) begin : g_bad_width
    $error("core_alu_serial: WIDTH must be 8, 16, 24 or 32");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             dec_q, dec_d, we_q, we_d, chain_q, chain_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [3:0]       fin_q, fin_d, flags_q, flags_d;
  logic [WIDTH-1:0] lhs_q, lhs_d, rhs_q, rhs_d, work_q, work_d, result_q, result_d;
  logic             accept, last, sub, c_out, arith_op, carry_op, v_top;
  logic [1:0]       idx;
  logic [7:0]       a, b, bx, byte_out;
  logic [8:0]       bin, arith;
  logic [4:0]       lo, hi;
  // One BCD digit: {carry/no-borrow, adjusted digit}; non-BCD inputs just follow the same rule.
  function automatic logic [4:0] nib(input logic [3:0] x, input logic [3:0] y,
                                     input logic ci, input logic sb);
    logic [4:0] s;
    s = {1'b0, x} + {1'b0, sb ? ~y : y} + {4'b0, ci};
    nib = sb ? {s[4], s[4] ? s[3:0] : s[3:0] - 4'd6}
             : (s > 5'd9 ? {1'b1, s[3:0] + 4'd6} : s);
  endfunction
  always_comb begin
    accept   = bus.I_start && state_q != RUN;
    last     = cnt_q == 2'(BYTES - 1);
    idx      = op_q == OP_ROR ? 2'(BYTES - 1) - cnt_q : cnt_q;
    a        = lhs_q[idx*8 +: 8];
    b        = rhs_q[idx*8 +: 8];
    sub      = op_q == OP_SBC;
    bx       = sub ? ~b : b;
    bin      = {1'b0, a} + {1'b0, bx} + {8'b0, chain_q};
    lo       = nib(a[3:0], b[3:0], chain_q, sub);
    hi       = nib(a[7:4], b[7:4], lo[4], sub);
    arith    = dec_q ? {hi, lo[3:0]} : bin;
    arith_op = op_q == OP_ADC || op_q == OP_SBC;
    carry_op = arith_op || op_q == OP_ROL || op_q == OP_ROR;
    c_out    = chain_q;
    byte_out = b;
    case (op_q)
      OP_ADC, OP_SBC: {c_out, byte_out} = arith;
      OP_AND:         byte_out = a & b;
      OP_ORA:         byte_out = a | b;
      OP_EOR:         byte_out = a ^ b;
      OP_ROL:         {c_out, byte_out} = {a[7], a[6:0], chain_q};
      OP_ROR:         {c_out, byte_out} = {a[0], chain_q, a[7:1]};
      default:        byte_out = b;
    endcase
    v_top    = (a[7] == bx[7]) && (byte_out[7] != a[7]);
    state_d  = accept ? RUN : state_q == RUN ? (last ? DONE : RUN) : IDLE;
    busy_d   = state_d == RUN;
    done_d   = state_q == RUN && last;
    cnt_d    = cnt_q;
    op_d     = op_q;
    dec_d    = dec_q;
    we_d     = we_q;
    chain_d  = chain_q;
    fin_d    = fin_q;
    lhs_d    = lhs_q;
    rhs_d    = rhs_q;
    work_d   = work_q;
    result_d = result_q;
    flags_d  = flags_q;
    if (accept) begin
      cnt_d   = 2'd0;
      op_d    = bus.I_op;
      dec_d   = bus.I_decimal && DECIMAL_EN;
      we_d    = bus.I_flag_we;
      chain_d = bus.I_carry;
      fin_d   = {bus.I_carry, bus.I_overflow, bus.I_sign, bus.I_zero};
      lhs_d   = bus.I_lhs;
      rhs_d   = bus.I_rhs;
      work_d  = '0;
    end else if (state_q == RUN) begin
      work_d[idx*8 +: 8] = byte_out;
      chain_d            = c_out;
      cnt_d              = cnt_q + 2'd1;
      if (last) begin
        result_d = work_d;
        flags_d  = we_q ? {carry_op ? c_out : fin_q[3], arith_op ? v_top : fin_q[2],
                           work_d[WIDTH-1], work_d == '0} : fin_q;
      end
    end
  end
  always_ff @(posedge I_clock or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      dec_q    <= 1'b0;
      we_q     <= 1'b0;
      chain_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fin_q    <= '0;
      flags_q  <= '0;
      lhs_q    <= '0;
      rhs_q    <= '0;
      work_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      dec_q    <= dec_d;
      we_q     <= we_d;
      chain_q  <= chain_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fin_q    <= fin_d;
      flags_q  <= flags_d;
      lhs_q    <= lhs_d;
      rhs_q    <= rhs_d;
      work_q   <= work_d;
      result_q <= result_d;
    end
  end
  assign bus.O_busy     = busy_q;
  assign bus.O_done     = done_q;
  assign bus.O_result   = result_q;
  assign bus.O_carry    = flags_q[3];
  assign bus.O_overflow = flags_q[2];
  assign bus.O_sign     = flags_q[1];
  assign bus.O_zero     = flags_q[0];
endmodule
